// File: rtl/param_barrel_rotator.sv
// param_barrel_rotator: pipelined rotate/shift unit with valid/ready handshakes and a sideband tag
module param_barrel_rotator #(
  parameter int WIDTH = 16,
  parameter int SHW = $clog2(WIDTH),
  parameter int LAT = 2,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]  in_amt,
  input  logic [2:0]      in_op,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            out_zero
);
  localparam int SPS = (SHW + LAT - 1) / LAT;
  logic [LAT-1:0]   vld_d, vld_q, fill_d, fill_q;
  logic [WIDTH-1:0] dat_d [LAT];
  logic [WIDTH-1:0] dat_q [LAT];
  logic [SHW-1:0]   amt_d [LAT];
  logic [SHW-1:0]   amt_q [LAT];
  logic [2:0]       op_d [LAT];
  logic [2:0]       op_q [LAT];
  logic [TAGW-1:0]  tag_d [LAT];
  logic [TAGW-1:0]  tag_q [LAT];
  logic             zero_d, zero_q, adv;

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  function automatic logic is_right(input logic [2:0] op);
    return op == 3'd1 || op == 3'd3 || op == 3'd4;
  endfunction

  function automatic logic is_rot(input logic [2:0] op);
    return op == 3'd0 || op == 3'd1;
  endfunction

  // one log-step: left by 2^k, wrapping for rotates, else filling with fill
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic rot,
                                            input logic fill, input int k);
    int sh;
    sh = 1 << k;
    return rot ? (d << sh) | (d >> (WIDTH - sh))
               : (d << sh) | ({WIDTH{fill}} & ((WIDTH'(1) << sh) - WIDTH'(1)));
  endfunction

  assign out_valid = vld_q[LAT-1];
  assign out_data  = dat_q[LAT-1];
  assign out_tag   = tag_q[LAT-1];
  assign out_zero  = zero_q;
  assign adv       = out_ready || !out_valid;
  assign in_ready  = adv;

  always_comb begin
    dat_d[0]  = is_right(in_op) ? rev(in_data) : in_data;
    amt_d[0]  = in_op > 3'd4 ? '0 : in_amt;
    op_d[0]   = in_op;
    fill_d[0] = (in_op == 3'd4) & in_data[WIDTH-1];
    tag_d[0]  = in_tag;
    vld_d[0]  = in_valid;
    for (int s = 1; s < LAT; s++) begin
      dat_d[s]  = dat_q[s-1];
      amt_d[s]  = amt_q[s-1];
      op_d[s]   = op_q[s-1];
      fill_d[s] = fill_q[s-1];
      tag_d[s]  = tag_q[s-1];
      vld_d[s]  = vld_q[s-1];
    end
    for (int s = 0; s < LAT; s++)
      for (int k = 0; k < SHW; k++)
        if (k / SPS == s && amt_d[s][k]) dat_d[s] = step(dat_d[s], is_rot(op_d[s]), fill_d[s], k);
    dat_d[LAT-1] = is_right(op_d[LAT-1]) ? rev(dat_d[LAT-1]) : dat_d[LAT-1];
    zero_d = dat_d[LAT-1] == '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      fill_q <= '0;
      zero_q <= 1'b0;
      for (int s = 0; s < LAT; s++) begin
        dat_q[s] <= '0;
        amt_q[s] <= '0;
        op_q[s]  <= '0;
        tag_q[s] <= '0;
      end
    end else if (adv) begin
      vld_q  <= vld_d;
      fill_q <= fill_d;
      zero_q <= zero_d;
      for (int s = 0; s < LAT; s++) begin
        dat_q[s] <= dat_d[s];
        amt_q[s] <= amt_d[s];
        op_q[s]  <= op_d[s];
        tag_q[s] <= tag_d[s];
      end
    end
  end
endmodule

// File: tb/tb_param_barrel_rotator.sv
// tb_param_barrel_rotator: scoreboard bench over four parameterisations of the rotator
module tb_param_barrel_rotator;
  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iv [4];
  logic        ir [4];
  logic        ov [4];
  logic        ordy [4];
  logic        oz [4];
  logic [31:0] idat [4];
  logic [31:0] odat [4];
  logic [4:0]  iamt [4];
  logic [2:0]  iop [4];
  logic [3:0]  itag [4];
  logic [3:0]  otag [4];
  logic [15:0] od0, od2;
  logic [7:0]  od1;
  logic [31:0] od3;
  int          wid [4] = '{16, 8, 16, 32};
  int          lat [4] = '{2, 1, 4, 3};
  logic [3:0]  bp_pat = 4'b1001;
  exp_t        sbq [$];
  int          cur = 0, cyc = 0, n_cmp = 0, n_err = 0;
  logic        bp = 1'b0, chk_lat = 1'b1, held = 1'b0, use_exp = 1'b0;
  logic [31:0] nxt_exp, h_d;
  logic [3:0]  h_t;
  logic        h_z;

  always #5 clk = ~clk;

  assign odat[0] = {16'd0, od0};
  assign odat[1] = {24'd0, od1};
  assign odat[2] = {16'd0, od2};
  assign odat[3] = od3;

  param_barrel_rotator u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0][15:0]),
    .in_amt(iamt[0][3:0]), .in_op(iop[0]), .in_tag(itag[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_data(od0), .out_tag(otag[0]), .out_zero(oz[0]));
  param_barrel_rotator #(.WIDTH(8), .LAT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1][7:0]),
    .in_amt(iamt[1][2:0]), .in_op(iop[1]), .in_tag(itag[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_data(od1), .out_tag(otag[1]), .out_zero(oz[1]));
  param_barrel_rotator #(.WIDTH(16), .LAT(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2][15:0]),
    .in_amt(iamt[2][3:0]), .in_op(iop[2]), .in_tag(itag[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_data(od2), .out_tag(otag[2]), .out_zero(oz[2]));
  param_barrel_rotator #(.WIDTH(32), .LAT(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(idat[3]),
    .in_amt(iamt[3]), .in_op(iop[3]), .in_tag(itag[3]), .out_valid(ov[3]),
    .out_ready(ordy[3]), .out_data(od3), .out_tag(otag[3]), .out_zero(oz[3]));

  function automatic logic [31:0] model(logic [31:0] d, int a, logic [2:0] op, int w);
    logic [31:0] r = '0;
    for (int i = 0; i < w; i++)
      case (op)
        3'd0: r[(i + a) % w] = d[i];
        3'd1: r[i] = d[(i + a) % w];
        3'd2: r[i] = i >= a ? d[i - a] : 1'b0;
        3'd3: r[i] = i + a < w ? d[i + a] : 1'b0;
        3'd4: r[i] = i + a < w ? d[i + a] : d[w - 1];
        default: r[i] = d[i];
      endcase
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  task automatic step_cyc(output logic acc);
    exp_t e;
    ordy[cur] = bp ? bp_pat[cyc % 4] : 1'b1;
    @(negedge clk);
    acc = iv[cur] && ir[cur];
    chk("in_ready", 32'(ir[cur]), 32'(!(ov[cur] && !ordy[cur])));
    if (held) begin
      chk("hold_data", odat[cur], h_d);
      chk("hold_tag", 32'(otag[cur]), 32'(h_t));
      chk("hold_zero", 32'(oz[cur]), 32'(h_z));
    end
    held = ov[cur] && !ordy[cur];
    h_d = odat[cur];
    h_t = otag[cur];
    h_z = oz[cur];
    if (ov[cur] && ordy[cur]) begin
      chk("output_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("data", odat[cur], e.d);
        chk("tag", 32'(otag[cur]), 32'(e.t));
        chk("zero", 32'(oz[cur]), 32'(e.d == 0));
        if (chk_lat) chk("latency", 32'(cyc - e.c), 32'(lat[cur]));
      end
    end
    if (acc) begin
      e.d = use_exp ? nxt_exp : model(idat[cur], int'(iamt[cur]), iop[cur], wid[cur]);
      e.t = itag[cur];
      e.c = cyc;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(logic [31:0] d, int a, logic [2:0] op, logic [3:0] t, logic ue,
                      logic [31:0] ex);
    logic acc;
    int n = 0;
    idat[cur] = d;
    iamt[cur] = 5'(a);
    iop[cur] = op;
    itag[cur] = t;
    iv[cur] = 1'b1;
    use_exp = ue;
    nxt_exp = ex;
    do begin
      step_cyc(acc);
      n++;
    end while (!acc && n < 50);
    chk("accepted", 32'(acc), 32'd1);
    if (!bp) chk("no_stall", 32'(n), 32'd1);
  endtask

  task automatic drain();
    logic acc;
    int n = 0;
    iv[cur] = 1'b0;
    while (sbq.size() != 0 && n < 40) begin
      step_cyc(acc);
      n++;
    end
    chk("drained", 32'(sbq.size()), 32'd0);
  endtask

  task automatic rand_run(int n);
    logic [31:0] m = wid[cur] == 32 ? 32'hFFFF_FFFF : (32'h1 << wid[cur]) - 32'h1;
    for (int i = 0; i < n; i++)
      send($urandom & m, int'($urandom_range(0, wid[cur] - 1)), 3'($urandom_range(0, 7)),
           4'(i), 1'b0, 32'h0);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b1;
      idat[i] = '0;
      iamt[i] = '0;
      iop[i] = '0;
      itag[i] = '0;
    end
    #3;
    chk("reset_valid", 32'(ov[0]), 32'd0);
    chk("reset_data", odat[0], 32'd0);
    chk("reset_tag", 32'(otag[0]), 32'd0);
    chk("reset_zero", 32'(oz[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("ready_after_reset", 32'(ir[0]), 32'd1);
    send(32'h8001, 1, 3'd0, 4'h1, 1'b1, 32'h0003);
    send(32'h8001, 4, 3'd1, 4'h2, 1'b1, 32'h1800);
    send(32'h1234, 0, 3'd0, 4'h3, 1'b1, 32'h1234);
    send(32'hFFFF, 15, 3'd2, 4'h4, 1'b1, 32'h8000);
    send(32'h8000, 15, 3'd3, 4'h5, 1'b1, 32'h0001);
    send(32'h8000, 3, 3'd4, 4'h6, 1'b1, 32'hF000);
    send(32'h4000, 3, 3'd4, 4'h7, 1'b1, 32'h0800);
    send(32'h0001, 1, 3'd3, 4'h8, 1'b1, 32'h0000);
    send(32'hA5C3, 7, 3'd5, 4'h9, 1'b1, 32'hA5C3);
    send(32'hB00F, 0, 3'd4, 4'hA, 1'b1, 32'hB00F);
    send(32'h0001, 15, 3'd2, 4'hB, 1'b1, 32'h8000);
    drain();
    send(32'h1111, 2, 3'd0, 4'hC, 1'b0, 32'h0);
    send(32'h2222, 3, 3'd1, 4'hD, 1'b0, 32'h0);
    iv[0] = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov[0]), 32'd0);
    chk("midrst_data", odat[0], 32'd0);
    chk("midrst_tag", 32'(otag[0]), 32'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("ready_after_midrst", 32'(ir[0]), 32'd1);
    repeat (6) step_cyc(acc);
    bp = 1'b1;
    chk_lat = 1'b0;
    for (int i = 0; i < 8; i++)
      send(32'h1357 * (i + 1), (i * 5) % 16, 3'(i), 4'(i), 1'b0, 32'h0);
    drain();
    bp = 1'b0;
    chk_lat = 1'b1;
    rand_run(32);
    for (int k = 1; k < 4; k++) begin
      cur = k;
      rand_run(24);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
